// File: rtl/axi_lite_gp_bridge.sv
// AXI4-Lite slave that forwards single-word reads/writes onto a GP register bus
// with done/error completion, address-range decode and a per-path watchdog.
module axi_lite_gp_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_WORDS = 48,
  parameter int TIMEOUT = 16,
  localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8),
  localparam int GP_ADDR_WIDTH = C_S_AXI_ADDR_WIDTH - ADDR_LSB
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                        s_axi_awprot,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                        s_axi_arprot,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic                              write,
  output logic [GP_ADDR_WIDTH-1:0]          write_addrs,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     write_data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   write_strobe,
  input  logic                              write_done,
  input  logic                              write_error,
  output logic                              read,
  output logic [GP_ADDR_WIDTH-1:0]          read_addrs,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     read_data,
  input  logic                              read_done,
  input  logic                              read_error
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {W_IDLE, W_GP, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_GP, R_RESP} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic                     aw_held, w_held;
  logic                     aw_hs, w_hs, ar_hs, w_both, w_mapped, r_mapped;
  logic [GP_ADDR_WIDTH-1:0] aw_idx, ar_idx;
  logic [WD_W-1:0]          w_cnt, r_cnt;
  logic                     w_expire, r_expire;
  logic                     unused_ok;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

  // A channel transfers on the edge where its valid and ready are both high;
  // valid is never qualified by ready, and ready depends only on local state.
  assign aw_hs    = s_axi_awvalid & s_axi_awready;
  assign w_hs     = s_axi_wvalid & s_axi_wready;
  assign ar_hs    = s_axi_arvalid & s_axi_arready;
  assign aw_idx   = aw_hs ? s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB] : write_addrs;
  assign ar_idx   = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign w_both   = (aw_held | aw_hs) & (w_held | w_hs);
  assign w_mapped = 32'(aw_idx) < 32'(NUM_WORDS);
  assign r_mapped = 32'(ar_idx) < 32'(NUM_WORDS);
  assign w_expire = (TIMEOUT != 0) && (w_cnt == WD_LAST);
  assign r_expire = (TIMEOUT != 0) && (r_cnt == WD_LAST);

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (w_both) w_state_nxt = w_mapped ? W_GP : W_RESP;
      W_GP:    if (write_done || w_expire) w_state_nxt = W_RESP;
      W_RESP:  if (s_axi_bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = r_mapped ? R_GP : R_RESP;
      R_GP:    if (read_done || r_expire) r_state_nxt = R_RESP;
      R_RESP:  if (s_axi_rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = s_axi_aresetn && (w_state == W_IDLE) && !aw_held;
    s_axi_wready  = s_axi_aresetn && (w_state == W_IDLE) && !w_held;
    s_axi_bvalid  = (w_state == W_RESP);
    write         = (w_state == W_GP);
    s_axi_arready = s_axi_aresetn && (r_state == R_IDLE);
    s_axi_rvalid  = (r_state == R_RESP);
    read          = (r_state == R_GP);
  end

  // Write datapath: capture flags, GP bus, watchdog and registered bresp.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      write_addrs  <= '0;
      write_data   <= '0;
      write_strobe <= '0;
      w_cnt        <= '0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held     <= 1'b1;
        write_addrs <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held       <= 1'b1;
        write_data   <= s_axi_wdata;
        write_strobe <= s_axi_wstrb;
      end
      w_cnt <= (w_state == W_GP) ? w_cnt + 1'b1 : '0;
      if ((w_state == W_IDLE) && w_both && !w_mapped) s_axi_bresp <= RESP_DECERR;
      if (w_state == W_GP) begin
        if (write_done)    s_axi_bresp <= write_error ? RESP_SLVERR : RESP_OKAY;
        else if (w_expire) s_axi_bresp <= RESP_SLVERR;
      end
      if ((w_state == W_RESP) && s_axi_bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Read datapath: GP address, watchdog and registered rdata/rresp.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      read_addrs  <= '0;
      r_cnt       <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      r_cnt <= (r_state == R_GP) ? r_cnt + 1'b1 : '0;
      if ((r_state == R_IDLE) && ar_hs) begin
        read_addrs <= ar_idx;
        if (!r_mapped) begin
          s_axi_rdata <= '0;
          s_axi_rresp <= RESP_DECERR;
        end
      end
      if (r_state == R_GP) begin
        if (read_done) begin
          s_axi_rdata <= read_data;
          s_axi_rresp <= read_error ? RESP_SLVERR : RESP_OKAY;
        end else if (r_expire) begin
          s_axi_rdata <= '0;
          s_axi_rresp <= RESP_SLVERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_gp_bridge.sv
// Directed bench for axi_lite_gp_bridge: write/read paths, ordering, decode,
// watchdog and mid-access reset, checked against hand-computed values.
module tb_axi_lite_gp_bridge;

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_aresetn;
  logic [7:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [7:0]  s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        write;
  logic [5:0]  write_addrs;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_done;
  logic        write_error;
  logic        read;
  logic [5:0]  read_addrs;
  logic [31:0] read_data;
  logic        read_done;
  logic        read_error;

  int n_cmp = 0;
  int n_fail = 0;
  int hi_cnt;

  axi_lite_gp_bridge #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .NUM_WORDS(48), .TIMEOUT(16)
  ) dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .write(write), .write_addrs(write_addrs), .write_data(write_data),
    .write_strobe(write_strobe), .write_done(write_done), .write_error(write_error),
    .read(read), .read_addrs(read_addrs), .read_data(read_data),
    .read_done(read_done), .read_error(read_error)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  task automatic step();
    @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    s_axi_aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    write_done = 1'b0; write_error = 1'b0;
    read_data = '0; read_done = 1'b0; read_error = 1'b0;

    // Reset values
    step(); step();
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_valids", {s_axi_bvalid, s_axi_rvalid, write, read}, 0);
    check("rst_buses", {s_axi_rdata, s_axi_bresp, s_axi_rresp, write_addrs, read_addrs}, 0);
    check("rst_wbus", {write_data, write_strobe}, 0);
    s_axi_aresetn = 1'b1;
    #1;
    check("post_rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    // Mapped write, back-to-back handshakes, write_done tied high
    write_done = 1'b1;
    s_axi_awaddr = 8'h04; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("w1_write", write, 1);
    check("w1_addrs", write_addrs, 6'd1);
    check("w1_data", write_data, 32'h1234_5678);
    check("w1_strobe", write_strobe, 4'hF);
    check("w1_readies_low", {s_axi_awready, s_axi_wready, s_axi_bvalid}, 0);
    step();
    check("w1_write_drop", write, 0);
    check("w1_bvalid", s_axi_bvalid, 1);
    check("w1_bresp", s_axi_bresp, 2'b00);
    step();
    check("w1_bvalid_clr", s_axi_bvalid, 0);
    check("w1_readies_back", {s_axi_awready, s_axi_wready}, 2'b11);

    // Read with GP stall and delayed rready
    s_axi_araddr = 8'h08; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    step();
    s_axi_arvalid = 1'b0;
    check("r2_read_c1", read, 1);
    check("r2_addrs", read_addrs, 6'd2);
    check("r2_arready_low", s_axi_arready, 0);
    step();
    check("r2_read_c2", read, 1);
    step();
    check("r2_read_c3", read, 1);
    read_done = 1'b1; read_data = 32'hBABA_1195;
    step();
    read_done = 1'b0; read_data = 32'h0;
    check("r2_read_drop", read, 0);
    check("r2_rvalid", s_axi_rvalid, 1);
    check("r2_rdata", s_axi_rdata, 32'hBABA_1195);
    check("r2_rresp", s_axi_rresp, 2'b00);
    step();
    check("r2_rvalid_hold", s_axi_rvalid, 1);
    check("r2_rdata_hold", s_axi_rdata, 32'hBABA_1195);
    s_axi_rready = 1'b1;
    step();
    check("r2_rvalid_clr", s_axi_rvalid, 0);
    check("r2_arready_back", s_axi_arready, 1);

    // W two cycles ahead of AW, concurrent erroring read of word 0
    s_axi_wdata = 32'hCAFE_F00D; s_axi_wstrb = 4'h3; s_axi_wvalid = 1'b1;
    s_axi_araddr = 8'h00; s_axi_arvalid = 1'b1;
    read_done = 1'b1; read_error = 1'b1; read_data = 32'h1111_1111;
    step();
    s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    check("w3_wready_low", s_axi_wready, 0);
    check("w3_awready_high", s_axi_awready, 1);
    check("w3_no_write_yet", write, 0);
    check("w3_read", read, 1);
    step();
    check("w3_rvalid", s_axi_rvalid, 1);
    check("w3_rresp", s_axi_rresp, 2'b10);
    check("w3_rdata", s_axi_rdata, 32'h1111_1111);
    check("w3_still_no_write", {write, s_axi_wready}, 0);
    read_done = 1'b0; read_error = 1'b0;
    s_axi_awaddr = 8'h0C; s_axi_awvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    check("w3_write", write, 1);
    check("w3_addrs", write_addrs, 6'd3);
    check("w3_data", {write_data, write_strobe}, {32'hCAFE_F00D, 4'h3});
    check("w3_rvalid_clr", s_axi_rvalid, 0);
    step();
    check("w3_bvalid", s_axi_bvalid, 1);
    check("w3_bresp", s_axi_bresp, 2'b00);
    step();
    check("w3_idle", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b011);

    // Unmapped write 0xC0 and read 0xC4
    write_done = 1'b0; read_data = 32'hDEAD_BEEF;
    s_axi_awaddr = 8'hC0; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = 8'hC4; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    check("u4_no_gp", {write, read}, 0);
    check("u4_bvalid", s_axi_bvalid, 1);
    check("u4_bresp", s_axi_bresp, 2'b11);
    check("u4_rvalid", s_axi_rvalid, 1);
    check("u4_rresp", s_axi_rresp, 2'b11);
    check("u4_rdata", s_axi_rdata, 0);
    step();
    check("u4_no_gp_hold", {write, read, s_axi_bvalid, s_axi_rvalid}, 4'b0011);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    step();
    check("u4_clr", {s_axi_bvalid, s_axi_rvalid}, 0);
    read_data = 32'h0;

    // Write watchdog, then a late done pulse
    s_axi_bready = 1'b0;
    s_axi_awaddr = 8'h10; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_00AA; s_axi_wvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    hi_cnt = 0;
    while (write && hi_cnt < 40) begin
      hi_cnt++;
      step();
    end
    check("wd5_write_cycles", hi_cnt, 16);
    check("wd5_bvalid", s_axi_bvalid, 1);
    check("wd5_bresp", s_axi_bresp, 2'b10);
    s_axi_bready = 1'b1;
    step();
    step();
    step();
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    check("wd5_late_done_idle", {write, s_axi_bvalid}, 0);
    step();
    check("wd5_no_second_resp", {write, s_axi_bvalid, s_axi_awready}, 3'b001);

    // Read watchdog expiry
    s_axi_araddr = 8'h20; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    read_data = 32'h7777_7777;
    step();
    s_axi_arvalid = 1'b0;
    hi_cnt = 0;
    while (read && hi_cnt < 40) begin
      hi_cnt++;
      step();
    end
    check("wd6_read_cycles", hi_cnt, 16);
    check("wd6_rresp", {s_axi_rvalid, s_axi_rresp}, 3'b110);
    check("wd6_rdata", s_axi_rdata, 0);
    s_axi_rready = 1'b1;
    step();

    // Done arriving on the last watchdog cycle wins
    s_axi_araddr = 8'h24; s_axi_arvalid = 1'b1;
    step();
    s_axi_arvalid = 1'b0;
    for (int i = 1; i < 16; i++) step();
    check("wd7_read_c16", read, 1);
    read_done = 1'b1; read_data = 32'h5A5A_5A5A;
    step();
    read_done = 1'b0;
    check("wd7_rresp", {s_axi_rvalid, s_axi_rresp}, 3'b100);
    check("wd7_rdata", s_axi_rdata, 32'h5A5A_5A5A);
    step();

    // Reset mid-read, then a fresh read
    s_axi_araddr = 8'h14; s_axi_arvalid = 1'b1;
    step();
    s_axi_arvalid = 1'b0;
    check("rst8_read_active", read, 1);
    s_axi_aresetn = 1'b0;
    #1;
    check("rst8_readies_forced", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
    step();
    check("rst8_outputs", {read, write, s_axi_rvalid, s_axi_bvalid, read_addrs, s_axi_rdata}, 0);
    s_axi_aresetn = 1'b1;
    step();
    check("rst8_no_rvalid_a", {s_axi_rvalid, read}, 0);
    step();
    check("rst8_no_rvalid_b", {s_axi_rvalid, read, s_axi_arready}, 3'b001);
    s_axi_araddr = 8'h18; s_axi_arvalid = 1'b1;
    read_done = 1'b1; read_data = 32'h600D_CAFE;
    step();
    s_axi_arvalid = 1'b0;
    check("rst8_fresh_read", {read, read_addrs}, {1'b1, 6'd6});
    step();
    read_done = 1'b0;
    check("rst8_fresh_resp", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, 2'b00, 32'h600D_CAFE});
    step();
    check("rst8_fresh_clr", s_axi_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
